// File: rtl/bus_pkg.sv
// Shared types for the memory-bus sequencer and related blocks.
// Lane/address widths here fix the shape of the latched request.
package bus_pkg;

    localparam int WAIT_W     = 4;
    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 8;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_XFER,
        BUS_RESP
    } bus_state_t;

    typedef struct packed {
        logic                    write;
        logic                    word;
        logic [BUS_ADDR_W-1:0]   addr;
        logic [2*BUS_DATA_W-1:0] wdata;
    } bus_req_t;

    function automatic logic [BUS_DATA_W-1:0] lane_sel(
        input logic [2*BUS_DATA_W-1:0] d,
        input logic                    idx
    );
        return idx ? d[2*BUS_DATA_W-1:BUS_DATA_W] : d[BUS_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Loadable down-counter with zero flag; counts down while enabled.
// Load takes priority over counting, and the count parks at zero.
module bus_wait_timer
    import bus_pkg::*;
#(
    parameter int W = WAIT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (en && !zero) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/bus_access_unit.sv
// Byte/word memory-bus sequencer: splits 16-bit accesses into two
// byte cycles with programmable wait states and a one-cycle response.
module bus_access_unit
    import bus_pkg::*;
#(
    parameter int ADDR_W   = BUS_ADDR_W,
    parameter int DATA_W   = BUS_DATA_W,
    parameter int WAIT_CYC = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic                req_word,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic                rsp_valid,
    output logic [2*DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_re,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    // The latched request struct is sized by the package.
    if (ADDR_W != BUS_ADDR_W || DATA_W != BUS_DATA_W ||
        WAIT_CYC < 0 || WAIT_CYC > 15) begin : g_param_guard
        $error("bus_access_unit: unsupported parameter set");
    end

    localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT_CYC);

    bus_state_t          state;
    bus_state_t          state_nx;
    bus_req_t            req_q;
    logic                byte_idx;
    logic [2*DATA_W-1:0] lanes_q;
    logic [2*DATA_W-1:0] lanes_nx;
    logic [2*DATA_W-1:0] rsp_q;
    logic                accept;
    logic                tmr_zero;
    logic                tmr_load;
    logic                byte_done;
    logic                last_byte;

    assign accept    = (state == BUS_IDLE) && req_valid;
    assign byte_done = (state == BUS_XFER) && tmr_zero;
    assign last_byte = (byte_idx == req_q.word);
    assign tmr_load  = accept || (byte_done && !last_byte);

    bus_wait_timer #(
        .W(WAIT_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .en   (state == BUS_XFER),
        .value(WAIT_LD),
        .zero (tmr_zero)
    );

    always_comb begin
        lanes_nx = lanes_q;
        if (byte_idx) begin
            lanes_nx[2*DATA_W-1:DATA_W] = mem_rdata;
        end else begin
            lanes_nx[DATA_W-1:0] = mem_rdata;
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            BUS_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nx = BUS_XFER;
                end
            end
            BUS_XFER: begin
                mem_re    = ~req_q.write;
                mem_we    = req_q.write;
                mem_addr  = req_q.addr + ADDR_W'(byte_idx);
                mem_wdata = lane_sel(req_q.wdata, byte_idx);
                if (tmr_zero && last_byte) begin
                    state_nx = BUS_RESP;
                end
            end
            BUS_RESP: begin
                rsp_valid = 1'b1;
                state_nx  = BUS_IDLE;
            end
            default: begin
                state_nx = BUS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BUS_IDLE;
            req_q    <= '0;
            byte_idx <= 1'b0;
            lanes_q  <= '0;
            rsp_q    <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                req_q    <= '{write: req_write, word: req_word,
                              addr: req_addr, wdata: req_wdata};
                byte_idx <= 1'b0;
                lanes_q  <= '0;
            end
            if (byte_done) begin
                if (!req_q.write) begin
                    lanes_q <= lanes_nx;
                end
                if (!last_byte) begin
                    byte_idx <= 1'b1;
                end else begin
                    // Response data is frozen here so it holds until the next RESP.
                    rsp_q <= req_q.write ? '0 : lanes_nx;
                end
            end
        end
    end

    assign rsp_rdata = rsp_q;
    assign busy      = ~req_ready;

endmodule

// File: tb/tb_bus_access_unit.sv
// Directed bench for bus_access_unit: four instances, WAIT_CYC = 0..3,
// each with its own byte-wide memory model.
module tb_bus_access_unit;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        req_valid [N];
    logic        req_ready [N];
    logic        req_write [N];
    logic        req_word  [N];
    logic [15:0] req_addr  [N];
    logic [15:0] req_wdata [N];
    logic        rsp_valid [N];
    logic [15:0] rsp_rdata [N];
    logic [15:0] mem_addr  [N];
    logic        mem_re    [N];
    logic        mem_we    [N];
    logic [7:0]  mem_wdata [N];
    logic [7:0]  mem_rdata [N];
    logic        busy      [N];

    logic [7:0] mem [N][65536];

    logic        bd_we;
    int          bd_k;
    logic [15:0] bd_addr;
    logic [7:0]  bd_data;

    int pass_cnt = 0;
    int total_cnt = 0;
    int overlap_cnt = 0;

    logic        tr_re    [$];
    logic        tr_we    [$];
    logic [15:0] tr_addr  [$];
    logic [7:0]  tr_wdata [$];

    logic [7:0] refm [int];

    for (genvar g = 0; g < N; g++) begin : g_dut
        bus_access_unit #(
            .ADDR_W  (16),
            .DATA_W  (8),
            .WAIT_CYC(g)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_write(req_write[g]),
            .req_word (req_word[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_rdata(rsp_rdata[g]),
            .mem_addr (mem_addr[g]),
            .mem_re   (mem_re[g]),
            .mem_we   (mem_we[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g]),
            .busy     (busy[g])
        );
        assign mem_rdata[g] = mem[g][mem_addr[g]];
    end

    always @(posedge clk) begin
        if (bd_we) mem[bd_k][bd_addr] <= bd_data;
        for (int k = 0; k < N; k++) begin
            if (mem_we[k]) mem[k][mem_addr[k]] <= mem_wdata[k];
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (mem_re[k] && mem_we[k]) overlap_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic poke(input int k, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bd_we = 1'b1;
        bd_k = k;
        bd_addr = a;
        bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic run_op(
        input  int          k,
        input  logic        wr,
        input  logic        wd,
        input  logic [15:0] a,
        input  logic [15:0] wdat,
        output logic [15:0] rd,
        output int          lat,
        output bit          to
    );
        int n;
        tr_re.delete();
        tr_we.delete();
        tr_addr.delete();
        tr_wdata.delete();
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_word[k]  = wd;
        req_addr[k]  = a;
        req_wdata[k] = wdat;
        n = 0;
        while (!req_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        n = 0;
        while (!rsp_valid[k] && n < 100) begin
            tr_re.push_back(mem_re[k]);
            tr_we.push_back(mem_we[k]);
            tr_addr.push_back(mem_addr[k]);
            tr_wdata.push_back(mem_wdata[k]);
            @(posedge clk);
            #1;
            n++;
        end
        to  = (n >= 100);
        rd  = rsp_rdata[k];
        lat = n + 1;
    endtask

    task automatic test_reset();
        #2;
        for (int k = 0; k < N; k++) begin
            total_cnt++;
            if (req_ready[k] !== 1'b1 || busy[k] !== 1'b0 ||
                rsp_valid[k] !== 1'b0 || mem_re[k] !== 1'b0 ||
                mem_we[k] !== 1'b0) begin
                $display("FAIL reset_ctrl[%0d]: ready=%b busy=%b rsp=%b re=%b we=%b want 1 0 0 0 0",
                         k, req_ready[k], busy[k], rsp_valid[k], mem_re[k], mem_we[k]);
            end else pass_cnt++;
            total_cnt++;
            if (mem_addr[k] !== 16'h0 || mem_wdata[k] !== 8'h0 ||
                rsp_rdata[k] !== 16'h0) begin
                $display("FAIL reset_data[%0d]: addr=%h wdata=%h rdata=%h want 0 0 0",
                         k, mem_addr[k], mem_wdata[k], rsp_rdata[k]);
            end else pass_cnt++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_byte_read();
        logic [15:0] rd;
        int lat;
        bit to;
        poke(0, 16'h1234, 8'hAB);
        run_op(0, 1'b0, 1'b0, 16'h1234, 16'h0, rd, lat, to);
        total_cnt++;
        if (to !== 1'b0 || lat !== 2) begin
            $display("FAIL byte_read latency: got %0d (timeout=%0d) want 2", lat, to);
        end else pass_cnt++;
        total_cnt++;
        if (tr_re.size() !== 1 || tr_re[0] !== 1'b1 || tr_we[0] !== 1'b0 ||
            tr_addr[0] !== 16'h1234) begin
            $display("FAIL byte_read strobe: cycles=%0d re=%b we=%b addr=%h want 1 1 0 1234",
                     tr_re.size(), tr_re[0], tr_we[0], tr_addr[0]);
        end else pass_cnt++;
        total_cnt++;
        if (rd !== 16'h00AB) begin
            $display("FAIL byte_read data: got %h want 00ab", rd);
        end else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 16'h00AB) begin
            $display("FAIL byte_read one_shot: rsp=%b rdata=%h want 0 00ab",
                     rsp_valid[0], rsp_rdata[0]);
        end else pass_cnt++;
    endtask

    task automatic test_word_read_wait();
        logic [15:0] rd;
        int lat;
        bit to;
        logic [15:0] ea;
        poke(2, 16'hC000, 8'h34);
        poke(2, 16'hC001, 8'h12);
        run_op(2, 1'b0, 1'b1, 16'hC000, 16'h0, rd, lat, to);
        total_cnt++;
        if (to !== 1'b0 || lat !== 7) begin
            $display("FAIL word_read_wait latency: got %0d (timeout=%0d) want 7", lat, to);
        end else pass_cnt++;
        total_cnt++;
        if (tr_re.size() !== 6) begin
            $display("FAIL word_read_wait cycles: got %0d want 6", tr_re.size());
        end else pass_cnt++;
        for (int i = 0; i < 6 && i < tr_re.size(); i++) begin
            ea = (i < 3) ? 16'hC000 : 16'hC001;
            total_cnt++;
            if (tr_re[i] !== 1'b1 || tr_we[i] !== 1'b0 || tr_addr[i] !== ea) begin
                $display("FAIL word_read_wait cyc%0d: re=%b we=%b addr=%h want 1 0 %h",
                         i, tr_re[i], tr_we[i], tr_addr[i], ea);
            end else pass_cnt++;
        end
        total_cnt++;
        if (rd !== 16'h1234) begin
            $display("FAIL word_read_wait data: got %h want 1234", rd);
        end else pass_cnt++;
    endtask

    task automatic test_word_write_wrap();
        logic [15:0] rd;
        int lat;
        bit to;
        run_op(0, 1'b1, 1'b1, 16'hFFFF, 16'hBEEF, rd, lat, to);
        total_cnt++;
        if (to !== 1'b0 || lat !== 3) begin
            $display("FAIL word_write latency: got %0d (timeout=%0d) want 3", lat, to);
        end else pass_cnt++;
        total_cnt++;
        if (tr_we.size() !== 2 || tr_we[0] !== 1'b1 || tr_re[0] !== 1'b0 ||
            tr_addr[0] !== 16'hFFFF || tr_wdata[0] !== 8'hEF) begin
            $display("FAIL word_write lane0: cycles=%0d we=%b re=%b addr=%h data=%h want 2 1 0 ffff ef",
                     tr_we.size(), tr_we[0], tr_re[0], tr_addr[0], tr_wdata[0]);
        end else pass_cnt++;
        total_cnt++;
        if (tr_we.size() < 2 || tr_we[1] !== 1'b1 || tr_addr[1] !== 16'h0000 ||
            tr_wdata[1] !== 8'hBE) begin
            $display("FAIL word_write lane1: we=%b addr=%h data=%h want 1 0000 be",
                     tr_we[1], tr_addr[1], tr_wdata[1]);
        end else pass_cnt++;
        total_cnt++;
        if (rd !== 16'h0000) begin
            $display("FAIL word_write rdata: got %h want 0000", rd);
        end else pass_cnt++;
        total_cnt++;
        if (mem[0][16'hFFFF] !== 8'hEF || mem[0][16'h0000] !== 8'hBE) begin
            $display("FAIL word_write memory: ffff=%h 0000=%h want ef be",
                     mem[0][16'hFFFF], mem[0][16'h0000]);
        end else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [5:0] e_rdy;
        logic [5:0] e_rsp;
        logic [5:0] e_re;
        logic [5:0] e_we;
        int n;
        e_rdy = 6'b100100;
        e_rsp = 6'b010010;
        e_re  = 6'b000001;
        e_we  = 6'b001000;
        poke(0, 16'h0010, 8'h5A);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_word[0]  = 1'b0;
        req_addr[0]  = 16'h0010;
        req_wdata[0] = 16'h0;
        n = 0;
        while (!req_ready[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_write[0] = 1'b1;
        req_addr[0]  = 16'h0020;
        req_wdata[0] = 16'h00C3;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) req_valid[0] = 1'b0;
            total_cnt++;
            if (req_ready[0] !== e_rdy[i] || rsp_valid[0] !== e_rsp[i] ||
                mem_re[0] !== e_re[i] || mem_we[0] !== e_we[i]) begin
                $display("FAIL back_to_back cyc%0d: ready=%b rsp=%b re=%b we=%b want %b %b %b %b",
                         i, req_ready[0], rsp_valid[0], mem_re[0], mem_we[0],
                         e_rdy[i], e_rsp[i], e_re[i], e_we[i]);
            end else pass_cnt++;
            if (i == 0) begin
                total_cnt++;
                if (mem_addr[0] !== 16'h0010) begin
                    $display("FAIL back_to_back addr1: got %h want 0010", mem_addr[0]);
                end else pass_cnt++;
            end
            if (i == 1) begin
                total_cnt++;
                if (rsp_rdata[0] !== 16'h005A) begin
                    $display("FAIL back_to_back rdata1: got %h want 005a", rsp_rdata[0]);
                end else pass_cnt++;
            end
            if (i == 3) begin
                total_cnt++;
                if (mem_addr[0] !== 16'h0020 || mem_wdata[0] !== 8'hC3) begin
                    $display("FAIL back_to_back addr2: got %h/%h want 0020/c3",
                             mem_addr[0], mem_wdata[0]);
                end else pass_cnt++;
            end
            if (i == 4) begin
                total_cnt++;
                if (rsp_rdata[0] !== 16'h0000) begin
                    $display("FAIL back_to_back rdata2: got %h want 0000", rsp_rdata[0]);
                end else pass_cnt++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd;
        int lat;
        bit to;
        bit saw_rsp;
        poke(0, 16'h0300, 8'h77);
        poke(0, 16'h0301, 8'h66);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_word[0]  = 1'b1;
        req_addr[0]  = 16'h0300;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (mem_re[0] !== 1'b1 || mem_addr[0] !== 16'h0301) begin
            $display("FAIL reset_mid pre: re=%b addr=%h want 1 0301", mem_re[0], mem_addr[0]);
        end else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (mem_re[0] !== 1'b0 || mem_we[0] !== 1'b0 || rsp_valid[0] !== 1'b0 ||
            mem_addr[0] !== 16'h0) begin
            $display("FAIL reset_mid async: re=%b we=%b rsp=%b addr=%h want 0 0 0 0000",
                     mem_re[0], mem_we[0], rsp_valid[0], mem_addr[0]);
        end else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw_rsp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid[0] || mem_re[0]) saw_rsp = 1'b1;
        end
        total_cnt++;
        if (saw_rsp !== 1'b0 || req_ready[0] !== 1'b1) begin
            $display("FAIL reset_mid after: activity=%b ready=%b want 0 1", saw_rsp, req_ready[0]);
        end else pass_cnt++;
        run_op(0, 1'b0, 1'b0, 16'h0301, 16'h0, rd, lat, to);
        total_cnt++;
        if (to !== 1'b0 || lat !== 2 || rd !== 16'h0066) begin
            $display("FAIL reset_mid next: lat=%0d data=%h timeout=%0d want 2 0066 0", lat, rd, to);
        end else pass_cnt++;
    endtask

    task automatic test_random();
        int ks [3];
        logic [15:0] rd;
        logic [15:0] exp;
        logic [15:0] a;
        logic [15:0] a1;
        logic [15:0] wdat;
        logic [7:0] d;
        logic wr;
        logic wd;
        int lat;
        int elat;
        bit to;
        int k;
        ks[0] = 0;
        ks[1] = 1;
        ks[2] = 3;
        for (int j = 0; j < 3; j++) begin
            k = ks[j];
            for (int i = 0; i < 16; i++) begin
                a = 16'hFFF8 + 16'(i);
                d = 8'($urandom);
                poke(k, a, d);
                refm[k * 65536 + int'(a)] = d;
            end
            for (int i = 0; i < 25; i++) begin
                wr   = 1'($urandom_range(0, 1));
                wd   = 1'($urandom_range(0, 1));
                a    = 16'hFFF8 + 16'($urandom_range(0, 14));
                a1   = a + 16'd1;
                wdat = 16'($urandom);
                if (wr) begin
                    exp = 16'h0;
                    refm[k * 65536 + int'(a)] = wdat[7:0];
                    if (wd) refm[k * 65536 + int'(a1)] = wdat[15:8];
                end else if (wd) begin
                    exp = {refm[k * 65536 + int'(a1)], refm[k * 65536 + int'(a)]};
                end else begin
                    exp = {8'h00, refm[k * 65536 + int'(a)]};
                end
                elat = wd ? (3 + 2 * k) : (2 + k);
                run_op(k, wr, wd, a, wdat, rd, lat, to);
                total_cnt++;
                if (to !== 1'b0 || lat !== elat || rd !== exp) begin
                    $display("FAIL random w%0d op%0d wr=%b wd=%b addr=%h: lat=%0d data=%h want %0d %h",
                             k, i, wr, wd, a, lat, rd, elat, exp);
                end else pass_cnt++;
            end
        end
        total_cnt++;
        if (overlap_cnt !== 0) begin
            $display("FAIL strobe_overlap: got %0d cycles want 0", overlap_cnt);
        end else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        bd_we = 1'b0;
        bd_k = 0;
        bd_addr = '0;
        bd_data = '0;
        for (int k = 0; k < N; k++) begin
            req_valid[k] = 1'b0;
            req_write[k] = 1'b0;
            req_word[k]  = 1'b0;
            req_addr[k]  = '0;
            req_wdata[k] = '0;
        end
        test_reset();
        test_byte_read();
        test_word_read_wait();
        test_word_write_wrap();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
